// File: rtl/serializer6_pkg.sv
// Shared types and constants for the 6-bit serial frame controller.
// Optional parity bit is enabled by defining SERIALIZER6_PARITY_EN.
package serializer6_pkg;

  localparam int WORD_WIDTH = 6;
  localparam int BIT_CNT_W  = 3;
  localparam int PERIOD_W   = 8;

  // Level driven on the serial line whenever no frame is in flight.
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [WORD_WIDTH-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/serializer6_controller_bit_period_counter.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 while running and strobes
// period_end in the final cycle of each period; load restarts it at 0.
module bit_period_counter
  import serializer6_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic period_end,
  output logic last_next
);

  localparam logic [PERIOD_W-1:0] LAST = PERIOD_W'(BIT_CYCLES - 1);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;

  always_comb begin
    period_end = run && (cnt_q == LAST);
    cnt_d      = cnt_q;
    if (load || period_end) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
    // Lets the parent register outputs that belong to the last cycle of a period.
    last_next = (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serializer6_controller.sv
// Sequences a 6-bit LSB-first shift register into start/data/[parity]/stop
// serial frames. Parity bit present when SERIALIZER6_PARITY_EN is defined.
module serializer6_controller
  import serializer6_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic                  clockpulse,
  input  logic                  clear_,
  input  logic                  word_valid,
  input  logic [WORD_WIDTH-1:0] word,
  output logic                  word_ready,
  output logic                  serial_output,
  output logic                  frame_active,
  output logic                  frame_done,
  output state_t                dbg_state
);

  // Handshake: a word transfers on a rising edge where word_valid and
  // word_ready are both 1; word_ready is 1 in every IDLE cycle and 0 otherwise,
  // word_valid may drop at any time without a transfer.

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  serial_q, serial_d;
  logic                  done_q, done_d;
  logic                  load;
  logic                  run;
  logic                  period_end;
  logic                  last_next;
`ifdef SERIALIZER6_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign run = (state_q != IDLE);

  bit_period_counter #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_period (
    .clk        (clockpulse),
    .rst_n      (clear_),
    .load       (load),
    .run        (run),
    .period_end (period_end),
    .last_next  (last_next)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (word_valid) begin
          load      = 1'b1;
          data_d    = word;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (period_end) state_d = DATA;
      end
      DATA: begin
        if (period_end) begin
          data_d    = {1'b0, data_q[WORD_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          if (bit_cnt_q == BIT_CNT_W'(WORD_WIDTH - 1)) begin
            bit_cnt_d = '0;
`ifdef SERIALIZER6_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (period_end) state_d = STOP;
      end
      STOP: begin
        if (period_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SERIALIZER6_PARITY_EN
  assign parity_d = load ? even_parity(word) : parity_q;
`endif

  // Line and done flag are computed from the next state so that the
  // registered outputs line up with the state they belong to.
  always_comb begin
    serial_d = IDLE_LEVEL;
    case (state_d)
      IDLE:   serial_d = IDLE_LEVEL;
      START:  serial_d = 1'b0;
      DATA:   serial_d = data_d[0];
`ifdef SERIALIZER6_PARITY_EN
      PARITY: serial_d = parity_q;
`else
      PARITY: serial_d = IDLE_LEVEL;
`endif
      STOP:   serial_d = 1'b1;
      default: serial_d = IDLE_LEVEL;
    endcase
    done_d = (state_d == STOP) && last_next;
  end

  always_ff @(posedge clockpulse) begin
    if (!clear_) begin
      state_q   <= IDLE;
      data_q    <= '0;
      bit_cnt_q <= '0;
      serial_q  <= IDLE_LEVEL;
      done_q    <= 1'b0;
`ifdef SERIALIZER6_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q  <= serial_d;
      done_q    <= done_d;
`ifdef SERIALIZER6_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign word_ready    = (state_q == IDLE);
  assign frame_active  = (state_q != IDLE);
  assign serial_output = serial_q;
  assign frame_done    = done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_serializer6_controller.sv
// Self-checking bench for serializer6_controller: directed frame table,
// back-to-back, mid-frame reset, BIT_CYCLES=1 and randomized model checks.
module tb_serializer6_controller;
  import serializer6_pkg::*;

  localparam int BC = 4;
`ifdef SERIALIZER6_PARITY_EN
  localparam int NPER = 9;
`else
  localparam int NPER = 8;
`endif
  localparam int FL = NPER * BC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear_;
  logic       word_valid, word_valid1;
  logic [5:0] word, word1;
  logic       word_ready, serial_output, frame_active, frame_done;
  logic       word_ready1, serial_output1, frame_active1, frame_done1;
  state_t     dbg_state, dbg_state1;

  serializer6_controller #(.BIT_CYCLES(BC)) dut (
    .clockpulse    (clk),
    .clear_        (clear_),
    .word_valid    (word_valid),
    .word          (word),
    .word_ready    (word_ready),
    .serial_output (serial_output),
    .frame_active  (frame_active),
    .frame_done    (frame_done),
    .dbg_state     (dbg_state)
  );

  serializer6_controller #(.BIT_CYCLES(1)) dut1 (
    .clockpulse    (clk),
    .clear_        (clear_),
    .word_valid    (word_valid1),
    .word          (word1),
    .word_ready    (word_ready1),
    .serial_output (serial_output1),
    .frame_active  (frame_active1),
    .frame_done    (frame_done1),
    .dbg_state     (dbg_state1)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];  // {done, line} per expected cycle

  typedef struct {
    logic [5:0] w;
    logic [0:8] seq;  // start, d0..d5, parity, stop in transmit order
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic seq_level(input logic [0:8] seq, input int p);
    if (NPER == 8 && p == 7) return seq[8];
    return seq[p];
  endfunction

  // Reference: frame as a list of per-cycle {done, line} from the framing rules.
  task automatic push_frame(input logic [5:0] w);
    logic lvl;
    for (int p = 0; p < NPER; p++) begin
      if (p == 0) lvl = 1'b0;
      else if (p <= 6) lvl = w[p-1];
      else if (NPER == 9 && p == 7) lvl = ^w;
      else lvl = 1'b1;
      for (int c = 0; c < BC; c++) exp_q.push_back({(p == NPER-1) && (c == BC-1), lvl});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_idle_line"},   serial_output, 1'b1);
    chk({tag, "_idle_ready"},  word_ready,    1'b1);
    chk({tag, "_idle_active"}, frame_active,  1'b0);
    chk({tag, "_idle_done"},   frame_done,    1'b0);
  endtask

  task automatic check_frame(input logic [0:8] seq, input string tag);
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      chk({tag, "_line"},   serial_output, seq_level(seq, i / BC));
      chk({tag, "_done"},   frame_done,    (i == FL-1));
      chk({tag, "_ready"},  word_ready,    1'b0);
      chk({tag, "_active"}, frame_active,  1'b1);
    end
  endtask

  task automatic send(input vec_t v, input string tag);
    @(negedge clk);
    word       = v.w;
    word_valid = 1'b1;
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    word       = 6'($urandom);
    check_frame(v.seq, tag);
    check_idle(tag);
  endtask

  // ---------------- test ----------------
  initial begin
    logic       l, d;
    logic [1:0] e;

    vecs[0] = '{6'b101101, 9'b0_101101_0_1};
    vecs[1] = '{6'b000111, 9'b0_111000_1_1};
    vecs[2] = '{6'h2A,     9'b0_010101_1_1};
    vecs[3] = '{6'h15,     9'b0_101010_1_1};
    vecs[4] = '{6'h3F,     9'b0_111111_0_1};
    vecs[5] = '{6'h00,     9'b0_000000_0_1};

    clear_      = 1'b0;
    word_valid  = 1'b0;
    word_valid1 = 1'b0;
    word        = '0;
    word1       = '0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_line",   serial_output, 1'b1);
    chk("rst_ready",  word_ready,    1'b1);
    chk("rst_active", frame_active,  1'b0);
    chk("rst_done",   frame_done,    1'b0);
    chk("rst_state",  8'(dbg_state), 8'(IDLE));
    clear_ = 1'b1;
    check_idle("post_rst");

    // Directed frame table
    for (int k = 0; k < 6; k++) send(vecs[k], $sformatf("vec%0d", k));

    // Back-to-back with word_valid held high
    @(negedge clk);
    word       = 6'h2A;
    word_valid = 1'b1;
    @(posedge clk);
    #1;
    word = 6'h15;
    check_frame(vecs[2].seq, "b2b_first");
    @(negedge clk);
    chk("b2b_gap_ready", word_ready,    1'b1);
    chk("b2b_gap_line",  serial_output, 1'b1);
    chk("b2b_gap_done",  frame_done,    1'b0);
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    word       = 6'($urandom);
    check_frame(vecs[3].seq, "b2b_second");
    check_idle("b2b");

    // Reset during DATA bit 3
    @(negedge clk);
    word       = 6'b011001;
    word_valid = 1'b1;
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    repeat (18) @(negedge clk);
    chk("abort_pre_state", 8'(dbg_state), 8'(DATA));
    chk("abort_pre_line",  serial_output, 1'b1);  // bit3 of 011001
    clear_ = 1'b0;
    @(negedge clk);
    chk("abort_line",   serial_output, 1'b1);
    chk("abort_done",   frame_done,    1'b0);
    chk("abort_ready",  word_ready,    1'b1);
    chk("abort_active", frame_active,  1'b0);
    chk("abort_state",  8'(dbg_state), 8'(IDLE));
    clear_ = 1'b1;
    check_idle("abort_rel");
    send(vecs[1], "after_abort");

    // BIT_CYCLES = 1 instance
    @(negedge clk);
    word1       = 6'h3F;
    word_valid1 = 1'b1;
    @(posedge clk);
    #1;
    word_valid1 = 1'b0;
    for (int i = 0; i < NPER; i++) begin
      @(negedge clk);
      chk("bc1_line",   serial_output1, seq_level(vecs[4].seq, i));
      chk("bc1_done",   frame_done1,    (i == NPER-1));
      chk("bc1_active", frame_active1,  1'b1);
    end
    @(negedge clk);
    chk("bc1_idle_ready", word_ready1,    1'b1);
    chk("bc1_idle_line",  serial_output1, 1'b1);

    // Randomized traffic against the queue model
    exp_q.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        d = e[1];
        l = e[0];
      end else begin
        d = 1'b0;
        l = 1'b1;
      end
      chk("rnd_line",   serial_output, l);
      chk("rnd_done",   frame_done,    d);
      chk("rnd_ready",  word_ready,    (exp_q.size() == 0));
      chk("rnd_active", frame_active,  (exp_q.size() != 0));
      word_valid = ($urandom_range(0, 3) == 0);
      word       = 6'($urandom);
      @(posedge clk);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      else if (word_valid) push_frame(word);
    end
    word_valid = 1'b0;

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
